asrv32_writeback: RTL and testbench

ASRV32_WRITEBACK -- requirements
Module: asrv32_writeback

---
 rtl/asrv32_writeback.sv | 189 ++++++++++++++++++
 tb/tb_asrv32_writeback.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/asrv32_writeback.sv
// Writeback stage: selects the result to write to the register file and waits for the
// data-memory response on loads, with a timeout, flush support and load error reporting.
module asrv32_writeback #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [1:0]  i_wb_sel,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_csr_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic        i_rdata_valid,
    input  logic [31:0] i_rdata,
    input  logic        i_flush,
    output logic        o_ce_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_load_err
);

    localparam int unsigned CNT_W = (LOAD_TIMEOUT < 1) ? 1 : $clog2(LOAD_TIMEOUT + 1);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_CSR  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [4:0]         ld_rd_addr, ld_rd_addr_nxt;
    logic               ld_wr_rd, ld_wr_rd_nxt;
    logic [2:0]         ld_funct3, ld_funct3_nxt;
    logic [1:0]         ld_lsb, ld_lsb_nxt;
    logic               ce_nxt, err_nxt;
    logic [4:0]         addr_nxt;
    logic [31:0]        data_nxt;

    logic               accept, is_load, load_bad, timeout_hit;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data, sel_data;

    assign o_ready     = (state == IDLE);
    assign accept      = i_valid && (state == IDLE) && !i_flush;
    assign is_load     = (i_wb_sel == SEL_LOAD);
    assign timeout_hit = (CNT_W'(cnt + CNT_W'(1)) == CNT_W'(LOAD_TIMEOUT));

    // Illegal funct3 or an access that is not naturally aligned.
    always_comb begin
        load_bad = 1'b0;
        case (i_funct3)
            F3_LB, F3_LBU: load_bad = 1'b0;
            F3_LH, F3_LHU: load_bad = i_addr_lsb[0];
            F3_LW:         load_bad = (i_addr_lsb != 2'b00);
            default:       load_bad = 1'b1;
        endcase
    end

    assign ld_byte = i_rdata[{ld_lsb, 3'b000} +: 8];
    assign ld_half = i_rdata[{ld_lsb[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = i_rdata;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = i_rdata;
        endcase
    end

    always_comb begin
        sel_data = i_alu_result;
        case (i_wb_sel)
            SEL_ALU: sel_data = i_alu_result;
            SEL_PC4: sel_data = i_pc_plus4;
            SEL_CSR: sel_data = i_csr_data;
            default: sel_data = i_alu_result;
        endcase
    end

    // State register plus registered outputs and captured load context.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_rd_addr <= '0;
            ld_wr_rd   <= 1'b0;
            ld_funct3  <= '0;
            ld_lsb     <= '0;
            o_ce_wr    <= 1'b0;
            o_load_err <= 1'b0;
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ld_rd_addr <= ld_rd_addr_nxt;
            ld_wr_rd   <= ld_wr_rd_nxt;
            ld_funct3  <= ld_funct3_nxt;
            ld_lsb     <= ld_lsb_nxt;
            o_ce_wr    <= ce_nxt;
            o_load_err <= err_nxt;
            o_rd_addr  <= addr_nxt;
            o_rd_data  <= data_nxt;
        end
    end

    // Next state, wait counter and load capture.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ld_rd_addr_nxt = ld_rd_addr;
        ld_wr_rd_nxt   = ld_wr_rd;
        ld_funct3_nxt  = ld_funct3;
        ld_lsb_nxt     = ld_lsb;
        case (state)
            IDLE: begin
                if (accept && is_load && !load_bad) begin
                    state_nxt      = WAIT_LOAD;
                    cnt_nxt        = '0;
                    ld_rd_addr_nxt = i_rd_addr;
                    ld_wr_rd_nxt   = i_wr_rd;
                    ld_funct3_nxt  = i_funct3;
                    ld_lsb_nxt     = i_addr_lsb;
                end
            end
            WAIT_LOAD: begin
                if (i_flush || i_rdata_valid || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = CNT_W'(cnt + CNT_W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered write port and error pulse.
    always_comb begin
        ce_nxt   = 1'b0;
        err_nxt  = 1'b0;
        addr_nxt = o_rd_addr;
        data_nxt = o_rd_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_load) begin
                        err_nxt = load_bad;
                    end else if (i_wr_rd && (i_rd_addr != 5'd0)) begin
                        ce_nxt   = 1'b1;
                        addr_nxt = i_rd_addr;
                        data_nxt = sel_data;
                    end
                end
            end
            WAIT_LOAD: begin
                if (!i_flush) begin
                    if (i_rdata_valid) begin
                        if (ld_wr_rd && (ld_rd_addr != 5'd0)) begin
                            ce_nxt   = 1'b1;
                            addr_nxt = ld_rd_addr;
                            data_nxt = ld_data;
                        end
                    end else if (timeout_hit) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_asrv32_writeback.sv
// Directed bench for asrv32_writeback with hand-computed expected values.
module tb_asrv32_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, wr_rd, rdata_valid, flush, ce_wr, load_err;
    logic [4:0]  rd_addr, o_rd_addr;
    logic [1:0]  wb_sel, addr_lsb;
    logic [2:0]  funct3;
    logic [31:0] alu_result, pc_plus4, csr_data, rdata, o_rd_data;

    int checks = 0;
    int failures = 0;

    asrv32_writeback #(.LOAD_TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_wr_rd(wr_rd), .i_rd_addr(rd_addr), .i_wb_sel(wb_sel),
        .i_alu_result(alu_result), .i_pc_plus4(pc_plus4), .i_csr_data(csr_data),
        .i_funct3(funct3), .i_addr_lsb(addr_lsb), .i_rdata_valid(rdata_valid),
        .i_rdata(rdata), .i_flush(flush), .o_ce_wr(ce_wr), .o_rd_addr(o_rd_addr),
        .o_rd_data(o_rd_data), .o_load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] lsb);
        valid = 1'b1; wr_rd = wr; rd_addr = rd; wb_sel = sel; funct3 = f3; addr_lsb = lsb;
        step();
        valid = 1'b0;
    endtask

    // Accept a load, hold the response off for nwait cycles, then check the write.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lsb, input int nwait, input logic [31:0] word,
                           input logic [31:0] exp);
        issue(1'b1, rd, 2'b01, f3, lsb);
        for (int i = 0; i < nwait; i++) begin
            check_eq({tag, "_ready_low"}, 32'(ready), 32'd0);
            if (i < nwait - 1) step();
        end
        rdata_valid = 1'b1; rdata = word;
        step();
        rdata_valid = 1'b0;
        check_eq({tag, "_ce"}, 32'(ce_wr), 32'd1);
        check_eq({tag, "_addr"}, 32'(o_rd_addr), 32'(rd));
        check_eq({tag, "_data"}, o_rd_data, exp);
        check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; wr_rd = 1'b0; rd_addr = '0; wb_sel = '0;
        alu_result = '0; pc_plus4 = '0; csr_data = '0; funct3 = '0; addr_lsb = '0;
        rdata_valid = 1'b0; rdata = '0; flush = 1'b0;
        #2;
        step(); step();
        rst_n = 1'b1;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_ce", 32'(ce_wr), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);
        check_eq("rst_addr", 32'(o_rd_addr), 32'd0);
        check_eq("rst_data", o_rd_data, 32'd0);

        // ALU write, then hold when idle
        alu_result = 32'h1234_5678;
        issue(1'b1, 5'd5, 2'b00, 3'b000, 2'b00);
        check_eq("alu_ce", 32'(ce_wr), 32'd1);
        check_eq("alu_addr", 32'(o_rd_addr), 32'd5);
        check_eq("alu_data", o_rd_data, 32'h1234_5678);
        check_eq("alu_ready", 32'(ready), 32'd1);
        step();
        check_eq("alu_ce_drop", 32'(ce_wr), 32'd0);
        check_eq("alu_hold_data", o_rd_data, 32'h1234_5678);
        check_eq("alu_hold_addr", 32'(o_rd_addr), 32'd5);

        // Back-to-back PC+4 and CSR writes
        pc_plus4 = 32'h0000_0104; csr_data = 32'hCAFE_F00D;
        valid = 1'b1; wr_rd = 1'b1; rd_addr = 5'd3; wb_sel = 2'b10;
        step();
        check_eq("pc4_data", o_rd_data, 32'h0000_0104);
        check_eq("pc4_addr", 32'(o_rd_addr), 32'd3);
        rd_addr = 5'd4; wb_sel = 2'b11;
        step();
        valid = 1'b0;
        check_eq("csr_ce", 32'(ce_wr), 32'd1);
        check_eq("csr_data", o_rd_data, 32'hCAFE_F00D);
        check_eq("csr_addr", 32'(o_rd_addr), 32'd4);

        // Load extraction variants
        do_load("lb",  5'd7,  3'b000, 2'd2, 3, 32'h0080_0000, 32'hFFFF_FF80);
        do_load("lbu", 5'd7,  3'b100, 2'd2, 3, 32'h0080_0000, 32'h0000_0080);
        do_load("lb3", 5'd8,  3'b000, 2'd3, 1, 32'h7F12_3456, 32'h0000_007F);
        do_load("lh",  5'd12, 3'b001, 2'd2, 2, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 5'd13, 3'b101, 2'd0, 1, 32'h1234_ABCD, 32'h0000_ABCD);
        do_load("lw",  5'd14, 3'b010, 2'd0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // rd = 0 and wr_rd = 0 never write
        alu_result = 32'h0BAD_0BAD;
        issue(1'b1, 5'd0, 2'b00, 3'b000, 2'b00);
        check_eq("rd0_ce", 32'(ce_wr), 32'd0);
        check_eq("rd0_hold", o_rd_data, 32'hDEAD_BEEF);
        issue(1'b0, 5'd9, 2'b00, 3'b000, 2'b00);
        check_eq("nowr_ce", 32'(ce_wr), 32'd0);
        issue(1'b1, 5'd0, 2'b01, 3'b010, 2'b00);
        check_eq("lw_rd0_wait", 32'(ready), 32'd0);
        rdata_valid = 1'b1; rdata = 32'h5555_5555;
        step();
        rdata_valid = 1'b0;
        check_eq("lw_rd0_ce", 32'(ce_wr), 32'd0);
        check_eq("lw_rd0_ready", 32'(ready), 32'd1);

        // Misaligned / illegal loads
        issue(1'b1, 5'd6, 2'b01, 3'b010, 2'b01);
        check_eq("mis_lw_err", 32'(load_err), 32'd1);
        check_eq("mis_lw_ce", 32'(ce_wr), 32'd0);
        check_eq("mis_lw_ready", 32'(ready), 32'd1);
        step();
        check_eq("mis_lw_err_drop", 32'(load_err), 32'd0);
        issue(1'b1, 5'd6, 2'b01, 3'b101, 2'b11);
        check_eq("mis_lhu_err", 32'(load_err), 32'd1);
        issue(1'b1, 5'd6, 2'b01, 3'b011, 2'b00);
        check_eq("ill_f3_err", 32'(load_err), 32'd1);
        check_eq("ill_f3_ready", 32'(ready), 32'd1);

        // Timeout after four wait cycles, then a stale response is ignored
        issue(1'b1, 5'd9, 2'b01, 3'b010, 2'b00);
        check_eq("to_err_w1", 32'(load_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("to_ready_low", 32'(ready), 32'd0);
            step();
        end
        check_eq("to_ready_low4", 32'(ready), 32'd0);
        step();
        check_eq("to_err", 32'(load_err), 32'd1);
        check_eq("to_ready", 32'(ready), 32'd1);
        check_eq("to_ce", 32'(ce_wr), 32'd0);
        rdata_valid = 1'b1; rdata = 32'h1111_1111;
        step();
        rdata_valid = 1'b0;
        check_eq("late_ce", 32'(ce_wr), 32'd0);
        check_eq("late_err", 32'(load_err), 32'd0);
        check_eq("late_ready", 32'(ready), 32'd1);

        // Flush beats a same-cycle response
        issue(1'b1, 5'd10, 2'b01, 3'b010, 2'b00);
        flush = 1'b1; rdata_valid = 1'b1; rdata = 32'h2222_2222;
        step();
        flush = 1'b0; rdata_valid = 1'b0;
        check_eq("flush_ce", 32'(ce_wr), 32'd0);
        check_eq("flush_err", 32'(load_err), 32'd0);
        check_eq("flush_ready", 32'(ready), 32'd1);

        // Flush in IDLE drops an accepted instruction
        flush = 1'b1; alu_result = 32'h3333_3333;
        issue(1'b1, 5'd11, 2'b00, 3'b000, 2'b00);
        flush = 1'b0;
        check_eq("idle_flush_ce", 32'(ce_wr), 32'd0);
        check_eq("idle_flush_data", o_rd_data, 32'hDEAD_BEEF);

        // Reset mid-wait discards the load
        issue(1'b1, 5'd11, 2'b01, 3'b010, 2'b00);
        rst_n = 1'b0;
        step();
        check_eq("mrst_ready", 32'(ready), 32'd1);
        check_eq("mrst_ce", 32'(ce_wr), 32'd0);
        check_eq("mrst_err", 32'(load_err), 32'd0);
        check_eq("mrst_addr", 32'(o_rd_addr), 32'd0);
        check_eq("mrst_data", o_rd_data, 32'd0);
        rst_n = 1'b1; rdata_valid = 1'b1; rdata = 32'h4444_4444;
        step();
        rdata_valid = 1'b0;
        check_eq("post_rst_ce", 32'(ce_wr), 32'd0);
        check_eq("post_rst_data", o_rd_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
